// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage sitting directly after EXE.
//
// Takes the EXE/MEM register outputs and performs data-memory loads and stores
// over a req/ack bus. It formats load data by byte lane, with sign or zero
// extension, and registers the retired result into the MEM/WB outputs. While a
// memory access is outstanding it stalls upstream.
//
// Ports
//   CLK, RESET            clock, asynchronous active-low reset
//   *1_IN                 EXE/MEM register fields. Upstream holds them stable
//                         while STALL_OUT is high.
//   *1_OUT                MEM/WB register fields (registered)
//   Fwd_MEMWrite_OUT      combinational copy of ALU_result1_IN for EX forwarding
//   STALL_OUT             combinational; upstream holds its registers while high
//   DMEM_*                data-memory request bus. ADDR/WDATA/BE/WE/REQ are
//                         registered and stay stable until DMEM_ACK.
//   ADDR_EXC_OUT          one-cycle pulse when a misaligned access retires
//   BUS_ERR_OUT           one-cycle pulse when an access retires on timeout
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int         TIMEOUT = 16,
    parameter logic [5:0] OP_LB   = 6'h20,
    parameter logic [5:0] OP_LH   = 6'h21,
    parameter logic [5:0] OP_LW   = 6'h23,
    parameter logic [5:0] OP_LBU  = 6'h24,
    parameter logic [5:0] OP_LHU  = 6'h25,
    parameter logic [5:0] OP_SB   = 6'h28,
    parameter logic [5:0] OP_SH   = 6'h29,
    parameter logic [5:0] OP_SW   = 6'h2B
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic [31:0] ALU_result1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic        RegWrite1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    input  logic [5:0]  ALU_Control1_IN,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] WriteData1_OUT,
    output logic [4:0]  WriteRegister1_OUT,
    output logic        RegWrite1_OUT,
    output logic [31:0] Fwd_MEMWrite_OUT,
    output logic        STALL_OUT,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BE,
    output logic        DMEM_WE,
    output logic        DMEM_REQ,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic        ADDR_EXC_OUT,
    output logic        BUS_ERR_OUT
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Access size. A store decodes only store codes, and an unknown code means word.
    function automatic logic [1:0] access_size(input logic [5:0] op, input logic is_store);
        logic [1:0] sz;
        if (is_store) begin
            case (op)
                OP_SB:   sz = SZ_B;
                OP_SH:   sz = SZ_H;
                OP_SW:   sz = SZ_W;
                default: sz = SZ_W;
            endcase
        end else begin
            case (op)
                OP_LB, OP_LBU: sz = SZ_B;
                OP_LH, OP_LHU: sz = SZ_H;
                OP_LW:         sz = SZ_W;
                default:       sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes so the byte enables alone pick the target.
    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Little-endian lane select, then sign or zero extension.
    function automatic logic [31:0] format_load(input logic [1:0] sz, input logic sgn,
                                                input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rd >> {off, 3'b000};
        case (sz)
            SZ_B:    r = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'h000000, sh[7:0]};
            SZ_H:    r = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
            default: r = rd;
        endcase
        return r;
    endfunction

    // state / counter
    state_t        state_r, nxt_state_s;
    logic [CW-1:0] cnt_r, nxt_cnt_s;

    // fields of the access in flight, captured at issue
    logic [1:0]  size_r;
    logic        sgn_r, store_r, regwrite_r;
    logic [1:0]  off_r;
    logic [4:0]  wreg_r;
    logic [31:0] instr_r, pc_r, alu_r;

    // registered outputs and their next values
    logic [31:0] instr_out_r, pc_out_r, wdata_out_r, nxt_instr_s, nxt_pc_s, nxt_wdata_s;
    logic [4:0]  wreg_out_r, nxt_wreg_s;
    logic        regwrite_out_r, nxt_regwrite_s;
    logic [31:0] dmem_addr_r, dmem_wdata_r, nxt_dmem_addr_s, nxt_dmem_wdata_s;
    logic [3:0]  dmem_be_r, nxt_dmem_be_s;
    logic        dmem_we_r, dmem_req_r, nxt_dmem_we_s, nxt_dmem_req_s;
    logic        addr_exc_r, bus_err_r, nxt_addr_exc_s, nxt_bus_err_s;

    // input decode
    logic       memop_s, is_store_s, misalign_s, issue_s, stall_s;
    logic [1:0] size_s;
    logic [31:0] fwd_s;

    assign memop_s    = MemRead1_IN | MemWrite1_IN;
    assign is_store_s = MemWrite1_IN;
    assign size_s     = access_size(ALU_Control1_IN, is_store_s);
    assign misalign_s = misaligned(size_s, ALU_result1_IN[1:0]);
    assign issue_s    = (state_r == IDLE) & memop_s & ~misalign_s;

    // Stall is held low during reset. In BUSY it also falls on the timeout edge,
    // because the faulting access retires there and upstream must move on.
    always_comb begin
        stall_s = 1'b0;
        if (!RESET) begin
            stall_s = 1'b0;
        end else if (state_r == IDLE) begin
            stall_s = issue_s;
        end else begin
            stall_s = ~(DMEM_ACK | (cnt_r == CNT_LAST));
        end
    end

    // Forwarding copy of the ALU result, forced to zero during reset.
    always_comb begin
        fwd_s = 32'h0000_0000;
        if (RESET) begin
            fwd_s = ALU_result1_IN;
        end else begin
            fwd_s = 32'h0000_0000;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        nxt_state_s      = state_r;
        nxt_cnt_s        = cnt_r;
        nxt_instr_s      = instr_out_r;
        nxt_pc_s         = pc_out_r;
        nxt_wdata_s      = wdata_out_r;
        nxt_wreg_s       = wreg_out_r;
        nxt_regwrite_s   = regwrite_out_r;
        nxt_dmem_addr_s  = dmem_addr_r;
        nxt_dmem_wdata_s = dmem_wdata_r;
        nxt_dmem_be_s    = dmem_be_r;
        nxt_dmem_we_s    = dmem_we_r;
        nxt_dmem_req_s   = dmem_req_r;
        nxt_addr_exc_s   = 1'b0;
        nxt_bus_err_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    nxt_state_s      = BUSY;
                    nxt_cnt_s        = CW'(0);
                    nxt_dmem_addr_s  = {ALU_result1_IN[31:2], 2'b00};
                    nxt_dmem_wdata_s = is_store_s ? store_lanes(size_s, MemWriteData1_IN) : 32'h0000_0000;
                    nxt_dmem_be_s    = byte_enables(size_s, ALU_result1_IN[1:0]);
                    nxt_dmem_we_s    = is_store_s;
                    nxt_dmem_req_s   = 1'b1;
                    nxt_instr_s      = 32'h0000_0000;
                    nxt_pc_s         = 32'h0000_0000;
                    nxt_regwrite_s   = 1'b0;
                end else begin
                    // non-memop, or misaligned memop retiring as an exception
                    nxt_instr_s    = Instr1_IN;
                    nxt_pc_s       = Instr1_PC_IN;
                    nxt_wdata_s    = ALU_result1_IN;
                    nxt_wreg_s     = WriteRegister1_IN;
                    nxt_regwrite_s = RegWrite1_IN & ~memop_s;
                    nxt_addr_exc_s = memop_s;
                end
            end
            BUSY: begin
                if (DMEM_ACK) begin
                    nxt_state_s    = IDLE;
                    nxt_dmem_req_s = 1'b0;
                    nxt_dmem_we_s  = 1'b0;
                    nxt_instr_s    = instr_r;
                    nxt_pc_s       = pc_r;
                    nxt_wreg_s     = wreg_r;
                    nxt_regwrite_s = regwrite_r & ~store_r;
                    nxt_wdata_s    = store_r ? alu_r : format_load(size_r, sgn_r, off_r, DMEM_RDATA);
                end else if (cnt_r == CNT_LAST) begin
                    nxt_state_s    = IDLE;
                    nxt_dmem_req_s = 1'b0;
                    nxt_dmem_we_s  = 1'b0;
                    nxt_instr_s    = instr_r;
                    nxt_pc_s       = pc_r;
                    nxt_wreg_s     = wreg_r;
                    nxt_regwrite_s = 1'b0;
                    nxt_wdata_s    = alu_r;
                    nxt_bus_err_s  = 1'b1;
                end else begin
                    nxt_cnt_s      = cnt_r + CW'(1);
                    nxt_instr_s    = 32'h0000_0000;
                    nxt_pc_s       = 32'h0000_0000;
                    nxt_regwrite_s = 1'b0;
                end
            end
            default: begin
                nxt_state_s    = IDLE;
                nxt_dmem_req_s = 1'b0;
                nxt_dmem_we_s  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r        <= IDLE;
            cnt_r          <= CW'(0);
            instr_out_r    <= 32'h0000_0000;
            pc_out_r       <= 32'h0000_0000;
            wdata_out_r    <= 32'h0000_0000;
            wreg_out_r     <= 5'd0;
            regwrite_out_r <= 1'b0;
            dmem_addr_r    <= 32'h0000_0000;
            dmem_wdata_r   <= 32'h0000_0000;
            dmem_be_r      <= 4'b0000;
            dmem_we_r      <= 1'b0;
            dmem_req_r     <= 1'b0;
            addr_exc_r     <= 1'b0;
            bus_err_r      <= 1'b0;
        end else begin
            state_r        <= nxt_state_s;
            cnt_r          <= nxt_cnt_s;
            instr_out_r    <= nxt_instr_s;
            pc_out_r       <= nxt_pc_s;
            wdata_out_r    <= nxt_wdata_s;
            wreg_out_r     <= nxt_wreg_s;
            regwrite_out_r <= nxt_regwrite_s;
            dmem_addr_r    <= nxt_dmem_addr_s;
            dmem_wdata_r   <= nxt_dmem_wdata_s;
            dmem_be_r      <= nxt_dmem_be_s;
            dmem_we_r      <= nxt_dmem_we_s;
            dmem_req_r     <= nxt_dmem_req_s;
            addr_exc_r     <= nxt_addr_exc_s;
            bus_err_r      <= nxt_bus_err_s;
        end
    end

    // Capture the issuing instruction so retirement does not depend on upstream.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            size_r     <= SZ_W;
            sgn_r      <= 1'b0;
            store_r    <= 1'b0;
            regwrite_r <= 1'b0;
            off_r      <= 2'b00;
            wreg_r     <= 5'd0;
            instr_r    <= 32'h0000_0000;
            pc_r       <= 32'h0000_0000;
            alu_r      <= 32'h0000_0000;
        end else if (issue_s) begin
            size_r     <= size_s;
            sgn_r      <= (ALU_Control1_IN == OP_LB) | (ALU_Control1_IN == OP_LH);
            store_r    <= is_store_s;
            regwrite_r <= RegWrite1_IN;
            off_r      <= ALU_result1_IN[1:0];
            wreg_r     <= WriteRegister1_IN;
            instr_r    <= Instr1_IN;
            pc_r       <= Instr1_PC_IN;
            alu_r      <= ALU_result1_IN;
        end else begin
            size_r     <= size_r;
            sgn_r      <= sgn_r;
            store_r    <= store_r;
            regwrite_r <= regwrite_r;
            off_r      <= off_r;
            wreg_r     <= wreg_r;
            instr_r    <= instr_r;
            pc_r       <= pc_r;
            alu_r      <= alu_r;
        end
    end

    assign Instr1_OUT         = instr_out_r;
    assign Instr1_PC_OUT      = pc_out_r;
    assign WriteData1_OUT     = wdata_out_r;
    assign WriteRegister1_OUT = wreg_out_r;
    assign RegWrite1_OUT      = regwrite_out_r;
    assign Fwd_MEMWrite_OUT   = fwd_s;
    assign STALL_OUT          = stall_s;
    assign DMEM_ADDR          = dmem_addr_r;
    assign DMEM_WDATA         = dmem_wdata_r;
    assign DMEM_BE            = dmem_be_r;
    assign DMEM_WE            = dmem_we_r;
    assign DMEM_REQ           = dmem_req_r;
    assign ADDR_EXC_OUT       = addr_exc_r;
    assign BUS_ERR_OUT        = bus_err_r;

endmodule
